uart_tx_arbiter: RTL

- Shares one 8N1-style UART transmit line between two byte requesters, A and B, using round-robin arbitration.
- Bit timing comes from the accumulator-MSB baud signal produced by the team's baud rate generator. That signal is a level, high about half of each period, not a one-cycle pulse.
- The block edge-detects that signal internally and advances the serial frame once per baud period.
- Sits between the command/telemetry byte sources and the board TX pin.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Purpose : requester-side handshake bundle between two byte sources (A, B) and uart_tx_arbiter.
// Latency : none, plain wires; a_ready/b_ready are driven combinationally by the arbiter.
// Backpressure: a source holds *_valid/*_data until it sees its one-cycle *_ready pulse.
// Ports   : a_valid/a_data, b_valid/b_data from the sources; a_ready/b_ready back from the arbiter.
//           modport master = byte source side, modport slave = arbiter side.
interface uart_tx_arbiter_if #(
   parameter int DATA_BITS = 8
);
   logic                 a_valid;
   logic [DATA_BITS-1:0] a_data;
   logic                 a_ready;
   logic                 b_valid;
   logic [DATA_BITS-1:0] b_data;
   logic                 b_ready;

   modport master (
      output a_valid, a_data, b_valid, b_data,
      input  a_ready, b_ready
   );

   modport slave (
      input  a_valid, a_data, b_valid, b_data,
      output a_ready, b_ready
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin share of one 8N1-style UART TX line between requesters A and B.
// Latency : accept in IDLE (ready same cycle); start bit at the next baud strobe, at most one baud period + 1 clk.
// Backpressure: ready pulses only in IDLE; a held valid simply waits until the current frame ends.
// Ports   : clk, reset_n (synchronous, active-low), baud_tick (baud generator MSB level),
//           req (slave modport: a/b valid, data, ready), tx (registered line, idle high),
//           busy, grant_b (1 = frame from B), frame_done (pulse in the cycle the last stop bit ends).
module uart_tx_arbiter #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             baud_tick,
   uart_tx_arbiter_if.slave req,
   output logic             tx,
   output logic             busy,
   output logic             grant_b,
   output logic             frame_done
);

   // Bit counter must reach DATA_BITS itself, so size it for DATA_BITS+1 values.
   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam int SCW = 2;

   localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS);
   localparam logic [BCW-1:0] BC_ONE  = BCW'(1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(STOP_BITS);
   localparam logic [SCW-1:0] SC_ONE  = SCW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t               state_q,    state_d;
   logic                 tick_q;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic [BCW-1:0]       bit_cnt_q,  bit_cnt_d;
   logic [SCW-1:0]       stop_cnt_q, stop_cnt_d;
   logic                 tx_q,       tx_d;
   logic                 busy_q,     busy_d;
   logic                 grant_b_q,  grant_b_d;
   // Priority pointer: 0 = A wins a tie, 1 = B wins a tie.
   logic                 ptr_b_q,    ptr_b_d;

   logic strobe;
   logic take_a;
   logic take_b;
   logic done;

   always_comb begin
      // The baud input is a level; only its rising edge advances the frame.
      strobe = baud_tick & ~tick_q;

      take_a = 1'b0;
      take_b = 1'b0;
      if (state_q == S_IDLE) begin
         if (req.a_valid && (!req.b_valid || !ptr_b_q)) begin
            take_a = 1'b1;
         end else if (req.b_valid) begin
            take_b = 1'b1;
         end
      end

      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      grant_b_d  = grant_b_q;
      ptr_b_d    = ptr_b_q;
      done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (take_a || take_b) begin
               shift_d   = take_b ? req.b_data : req.a_data;
               grant_b_d = take_b;
               // Loser of this round gets priority next time.
               ptr_b_d   = take_a;
               busy_d    = 1'b1;
               state_d   = S_ALIGN;
            end
         end

         // Frame start is asynchronous to the baud phase; wait for a
         // strobe so the start bit lasts a full baud period.
         S_ALIGN: begin
            if (strobe) begin
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end

         S_START: begin
            if (strobe) begin
               tx_d      = shift_q[0];
               shift_d   = shift_q >> 1;
               bit_cnt_d = BC_ONE;
               state_d   = S_DATA;
            end
         end

         S_DATA: begin
            if (strobe) begin
               if (bit_cnt_q < BC_LAST) begin
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + BC_ONE;
               end else begin
                  tx_d       = 1'b1;
                  stop_cnt_d = SC_ONE;
                  state_d    = S_STOP;
               end
            end
         end

         S_STOP: begin
            if (strobe) begin
               if (stop_cnt_q < SC_LAST) begin
                  stop_cnt_d = stop_cnt_q + SC_ONE;
               end else begin
                  done    = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         // Starts high so a baud level already high at release is not an edge.
         tick_q     <= 1'b1;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         grant_b_q  <= 1'b0;
         ptr_b_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= baud_tick;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         grant_b_q  <= grant_b_d;
         ptr_b_q    <= ptr_b_d;
      end
   end

   // Pulses are masked during reset so nothing looks accepted or finished
   // while the block is being cleared.
   assign req.a_ready = reset_n & take_a;
   assign req.b_ready = reset_n & take_b;
   assign frame_done  = reset_n & done;

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign grant_b = grant_b_q;

endmodule
